// File: rtl/rosc_timer_seq.sv
`default_nettype none
// ============================================================================
//  Module   : rosc_timer_seq
//  Purpose  : Measurement sequencer for the ring-oscillator timer. Issues
//             stretched clear/start/stop pulses around a programmable gate
//             window, then captures the timer's asynchronous elapsed count
//             through a 2-flop synchronizer plus a stability filter and
//             hands the result to the host on a valid/ready handshake.
//  Ports    :
//    clk           in   system clock
//    rst           in   synchronous active-high reset
//    go            in   start one measurement (honoured in IDLE only)
//    gate_len[16]  in   gate window in clk cycles (0 treated as 1)
//    busy          out  high whenever the sequencer is not idle
//    timer_clear   out  registered clear pulse to the timer
//    timer_start   out  registered start pulse to the timer
//    timer_stop    out  registered stop pulse to the timer
//    timer_count   in   timer elapsed count (asynchronous to clk)
//    result[32]    out  accepted count
//    result_err    out  count taken on settle timeout, not on stability
//    result_valid  out  result available
//    result_ready  in   consumer accepts result
//  Revision : 1.0  initial release
// ============================================================================
module rosc_timer_seq #(
  parameter int HOLD_CYCLES  = 4,
  parameter int STABLE_READS = 2,
  parameter int SETTLE_MAX   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [15:0] gate_len,
  output logic        busy,
  output logic        timer_clear,
  output logic        timer_start,
  output logic        timer_stop,
  input  logic [31:0] timer_count,
  output logic [31:0] result,
  output logic        result_err,
  output logic        result_valid,
  input  logic        result_ready
);

  // --------------------------------------------------------------------------
  // Counter widths and terminal values
  // --------------------------------------------------------------------------
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int STAB_W = $clog2(STABLE_READS + 1);
  localparam int SETL_W = $clog2(SETTLE_MAX + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = {HOLD_W{1'b1}};
  localparam logic [STAB_W-1:0] STAB_TGT  = STAB_W'(STABLE_READS);
  localparam logic [STAB_W-1:0] STAB_SAT  = {STAB_W{1'b1}};
  localparam logic [SETL_W-1:0] SETL_TGT  = SETL_W'(SETTLE_MAX);
  localparam logic [SETL_W-1:0] SETL_SAT  = {SETL_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_START  = 3'd2,
    ST_GATE   = 3'd3,
    ST_STOP   = 3'd4,
    ST_SETTLE = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  state_t              state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [15:0]         gate_cnt;
  logic [STAB_W-1:0]   stable_cnt;
  logic [SETL_W-1:0]   settle_cnt;

  // Synchronizer chain: sync1 is the metastability flop, sync_q the first
  // usable sample, prev_q the sample one cycle older for the stability test.
  logic [31:0]         sync1;
  logic [31:0]         sync_q;
  logic [31:0]         prev_q;

  // --------------------------------------------------------------------------
  // Next values of the SETTLE counters. The capture decision is taken on the
  // incremented value so that the result lands the cycle after the final
  // qualifying comparison.
  // --------------------------------------------------------------------------
  logic                stable_eq;
  logic [STAB_W-1:0]   stable_nxt;
  logic [SETL_W-1:0]   settle_nxt;
  logic                stable_hit;
  logic                settle_hit;
  logic                hold_done;

  always_comb begin
    stable_eq  = (sync_q == prev_q);
    stable_nxt = '0;
    if (stable_eq) begin
      stable_nxt = (stable_cnt == STAB_SAT) ? stable_cnt : stable_cnt + STAB_W'(1);
    end
    settle_nxt = (settle_cnt == SETL_SAT) ? settle_cnt : settle_cnt + SETL_W'(1);
    stable_hit = (stable_nxt >= STAB_TGT);
    settle_hit = (settle_nxt >= SETL_TGT);
    hold_done  = (hold_cnt == HOLD_LAST);
  end

  // --------------------------------------------------------------------------
  // Sequencer. All outputs are registered here alongside the state so that
  // every timer control comes straight from a flop.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      hold_cnt     <= '0;
      gate_cnt     <= '0;
      stable_cnt   <= '0;
      settle_cnt   <= '0;
      sync1        <= '0;
      sync_q       <= '0;
      prev_q       <= '0;
      busy         <= 1'b0;
      timer_clear  <= 1'b0;
      timer_start  <= 1'b0;
      timer_stop   <= 1'b0;
      result       <= '0;
      result_err   <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      sync1  <= timer_count;
      sync_q <= sync1;
      prev_q <= sync_q;

      case (state)
        ST_IDLE: begin
          if (go) begin
            // A zero-length gate would never terminate the countdown.
            gate_cnt    <= (gate_len == 16'd0) ? 16'd1 : gate_len;
            hold_cnt    <= '0;
            timer_clear <= 1'b1;
            busy        <= 1'b1;
            state       <= ST_CLEAR;
          end
        end

        ST_CLEAR: begin
          if (hold_done) begin
            hold_cnt    <= '0;
            timer_clear <= 1'b0;
            timer_start <= 1'b1;
            state       <= ST_START;
          end else if (hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        ST_START: begin
          if (hold_done) begin
            hold_cnt    <= '0;
            timer_start <= 1'b0;
            state       <= ST_GATE;
          end else if (hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        ST_GATE: begin
          if (gate_cnt <= 16'd1) begin
            hold_cnt   <= '0;
            timer_stop <= 1'b1;
            state      <= ST_STOP;
          end else begin
            gate_cnt <= gate_cnt - 16'd1;
          end
        end

        ST_STOP: begin
          if (hold_done) begin
            hold_cnt   <= '0;
            timer_stop <= 1'b0;
            stable_cnt <= '0;
            settle_cnt <= '0;
            state      <= ST_SETTLE;
          end else if (hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        ST_SETTLE: begin
          stable_cnt <= stable_nxt;
          settle_cnt <= settle_nxt;
          // Stability is checked first so a simultaneous timeout still
          // reports a clean result.
          if (stable_hit) begin
            result       <= sync_q;
            result_err   <= 1'b0;
            result_valid <= 1'b1;
            state        <= ST_DONE;
          end else if (settle_hit) begin
            result       <= sync_q;
            result_err   <= 1'b1;
            result_valid <= 1'b1;
            state        <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= ST_IDLE;
          end
        end

        default: begin
          timer_clear  <= 1'b0;
          timer_start  <= 1'b0;
          timer_stop   <= 1'b0;
          result_valid <= 1'b0;
          busy         <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Structural invariants
  // --------------------------------------------------------------------------
  a_ctrl_onehot0 : assert property (@(posedge clk) disable iff (rst)
    $onehot0({timer_clear, timer_start, timer_stop}));

  a_valid_busy : assert property (@(posedge clk) disable iff (rst)
    result_valid |-> busy);

endmodule
`default_nettype wire

// File: tb/tb_rosc_timer_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rosc_timer_seq
//  Purpose  : Self-checking bench for rosc_timer_seq. Each measurement is
//             predicted cycle by cycle from the timing rules (pulse windows,
//             settle outcome computed from the applied timer_count history)
//             and compared with the DUT outputs sampled on the falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rosc_timer_seq;

  localparam int H    = 4;
  localparam int S    = 2;
  localparam int SM   = 64;
  localparam int MAXC = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic [15:0] gate_len;
  logic        busy;
  logic        timer_clear;
  logic        timer_start;
  logic        timer_stop;
  logic [31:0] timer_count;
  logic [31:0] result;
  logic        result_err;
  logic        result_valid;
  logic        result_ready;

  rosc_timer_seq #(
    .HOLD_CYCLES (H),
    .STABLE_READS(S),
    .SETTLE_MAX  (SM)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .go          (go),
    .gate_len    (gate_len),
    .busy        (busy),
    .timer_clear (timer_clear),
    .timer_start (timer_start),
    .timer_stop  (timer_stop),
    .timer_count (timer_count),
    .result      (result),
    .result_err  (result_err),
    .result_valid(result_valid),
    .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // timer_count applied in each cycle of a measurement (cycle 0 = go cycle)
  logic [31:0] tc     [MAXC];
  // observed outputs per cycle: ctl = {busy, clear, start, stop, valid}
  logic [4:0]  obs_ctl[MAXC];
  logic [31:0] obs_res[MAXC];
  logic        obs_err[MAXC];
  // expected outputs per cycle
  logic [4:0]  e_ctl  [MAXC];
  logic [31:0] e_res  [MAXC];
  logic        e_err  [MAXC];

  logic [31:0] prev_res;
  logic        prev_err;
  int          m_G, m_V, m_hs;
  logic [31:0] m_R;
  logic        m_E;

  // Reference: predicts the whole measurement from the timing rules.
  // sync_q in cycle c is timer_count of cycle c-2; the value one cycle older
  // is timer_count of cycle c-3.
  task automatic model(input logic [15:0] g, input int rdy_wait);
    int  f;
    int  cnt;
    int  c;
    bit  done;
    m_G  = (g == 16'd0) ? 1 : int'(g);
    f    = 3 * H + m_G + 1;
    cnt  = 0;
    done = 0;
    m_V  = 0;
    m_R  = '0;
    m_E  = 1'b0;
    for (int k = 1; k <= SM && !done; k++) begin
      c = f + k - 1;
      if (tc[c-2] == tc[c-3]) cnt++;
      else cnt = 0;
      if (cnt >= S) begin
        m_V = c + 1; m_R = tc[c-2]; m_E = 1'b0; done = 1;
      end else if (k >= SM) begin
        m_V = c + 1; m_R = tc[c-2]; m_E = 1'b1; done = 1;
      end
    end
    m_hs = m_V + rdy_wait;
    for (int cc = 0; cc <= m_hs; cc++) begin
      e_ctl[cc] = {(cc >= 1 && cc <= m_hs),
                   (cc >= 1 && cc <= H),
                   (cc > H && cc <= 2 * H),
                   (cc > 2 * H + m_G && cc <= 3 * H + m_G),
                   (cc >= m_V && cc <= m_hs)};
      e_res[cc] = (cc >= m_V) ? m_R : prev_res;
      e_err[cc] = (cc >= m_V) ? m_E : prev_err;
    end
    prev_res = m_R;
    prev_err = m_E;
  endtask

  // Drives one measurement starting at the next falling edge and records the
  // outputs seen in every cycle up to and including the handshake cycle.
  task automatic run_meas(input logic [15:0] g, input int rdy_wait, input bit noise_go);
    model(g, rdy_wait);
    for (int c = 0; c <= m_hs; c++) begin
      @(negedge clk);
      obs_ctl[c]   = {busy, timer_clear, timer_start, timer_stop, result_valid};
      obs_res[c]   = result;
      obs_err[c]   = result_err;
      go           = (c == 0) || (noise_go && c < m_hs && $urandom_range(0, 2) == 0);
      gate_len     = (c == 0) ? g : 16'($urandom);
      timer_count  = tc[c];
      result_ready = (c >= m_hs) ? 1'b1 : ((c < m_V) ? 1'($urandom) : 1'b0);
    end
    go           = 1'b0;
  endtask

  task automatic fill_const(input logic [31:0] v);
    for (int c = 0; c < MAXC; c++) tc[c] = v;
  endtask

  task automatic test_reset;
    rst = 1'b1; go = 1'b0; gate_len = '0; timer_count = '0; result_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({busy, timer_clear, timer_start, timer_stop, result_valid, result_err} !== 6'b0 ||
        result !== 32'h0) begin
      fails++;
      $display("FAIL reset: got ctl=%b%b%b%b v=%b e=%b res=%h, expected all 0",
               busy, timer_clear, timer_start, timer_stop, result_valid, result_err, result);
    end
    rst = 1'b0;
    prev_res = '0;
    prev_err = 1'b0;
  endtask

  task automatic test_basic;
    int ov;
    fill_const(32'h0000_1234);
    run_meas(16'd10, 0, 1'b0);
    for (int c = 0; c <= m_hs; c++) begin
      tests++;
      if (obs_ctl[c] !== e_ctl[c] || obs_res[c] !== e_res[c] || obs_err[c] !== e_err[c]) begin
        fails++;
        $display("FAIL basic cyc %0d: got ctl=%b res=%h err=%b, expected ctl=%b res=%h err=%b",
                 c, obs_ctl[c], obs_res[c], obs_err[c], e_ctl[c], e_res[c], e_err[c]);
      end
    end
    ov = -1;
    for (int c = 0; c <= m_hs; c++) if (obs_ctl[c][0] && ov < 0) ov = c;
    tests++;
    if (ov != 25 || obs_res[25] !== 32'h0000_1234 || obs_err[25] !== 1'b0) begin
      fails++;
      $display("FAIL basic_result: got valid@%0d res=%h err=%b, expected valid@25 res=00001234 err=0",
               ov, obs_res[25], obs_err[25]);
    end
  endtask

  task automatic test_noisy;
    int ov;
    logic [15:0] g;
    logic [31:0] want;
    g = 16'($urandom_range(1, 20));
    for (int c = 0; c < MAXC; c++) tc[c] = 32'hA5A5_0000 + 32'(c);
    run_meas(g, 1, 1'b0);
    for (int c = 0; c <= m_hs; c++) begin
      tests++;
      if (obs_ctl[c] !== e_ctl[c] || obs_res[c] !== e_res[c] || obs_err[c] !== e_err[c]) begin
        fails++;
        $display("FAIL noisy cyc %0d: got ctl=%b res=%h err=%b, expected ctl=%b res=%h err=%b",
                 c, obs_ctl[c], obs_res[c], obs_err[c], e_ctl[c], e_res[c], e_err[c]);
      end
    end
    ov = -1;
    for (int c = 0; c <= m_hs; c++) if (obs_ctl[c][0] && ov < 0) ov = c;
    want = 32'hA5A5_0000 + 32'(3 * H + int'(g) + 62);
    tests++;
    if (ov != 3 * H + int'(g) + 65 || result !== want || result_err !== 1'b1) begin
      fails++;
      $display("FAIL noisy_timeout: got valid@%0d res=%h err=%b, expected valid@%0d res=%h err=1",
               ov, result, result_err, 3 * H + int'(g) + 65, want);
    end
  endtask

  task automatic test_late_settle;
    int ov, f;
    logic [15:0] g;
    g = 16'($urandom_range(1, 15));
    f = 3 * H + int'(g) + 1;
    for (int c = 0; c < MAXC; c++)
      tc[c] = (c < f - 2) ? 32'h0BAD_0001 : (c < f) ? 32'h0BAD_0002 : 32'hDEAD_BEEF;
    run_meas(g, 2, 1'b0);
    for (int c = 0; c <= m_hs; c++) begin
      tests++;
      if (obs_ctl[c] !== e_ctl[c] || obs_res[c] !== e_res[c] || obs_err[c] !== e_err[c]) begin
        fails++;
        $display("FAIL late cyc %0d: got ctl=%b res=%h err=%b, expected ctl=%b res=%h err=%b",
                 c, obs_ctl[c], obs_res[c], obs_err[c], e_ctl[c], e_res[c], e_err[c]);
      end
    end
    ov = -1;
    for (int c = 0; c <= m_hs; c++) if (obs_ctl[c][0] && ov < 0) ov = c;
    tests++;
    if (ov != f + 5 || result !== 32'hDEAD_BEEF || result_err !== 1'b0) begin
      fails++;
      $display("FAIL late_result: got valid@%0d res=%h err=%b, expected valid@%0d res=deadbeef err=0",
               ov, result, result_err, f + 5);
    end
  endtask

  task automatic test_backpressure;
    fill_const($urandom);
    run_meas(16'($urandom_range(1, 12)), 10, 1'b1);
    for (int c = 0; c <= m_hs; c++) begin
      tests++;
      if (obs_ctl[c] !== e_ctl[c] || obs_res[c] !== e_res[c] || obs_err[c] !== e_err[c]) begin
        fails++;
        $display("FAIL backpressure cyc %0d: got ctl=%b res=%h err=%b, expected ctl=%b res=%h err=%b",
                 c, obs_ctl[c], obs_res[c], obs_err[c], e_ctl[c], e_res[c], e_err[c]);
      end
    end
    @(negedge clk);
    result_ready = 1'b0;
    tests++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || result !== prev_res) begin
      fails++;
      $display("FAIL backpressure_release: got busy=%b valid=%b res=%h, expected busy=0 valid=0 res=%h",
               busy, result_valid, result, prev_res);
    end
  endtask

  task automatic test_zero_gate;
    int first_stop, last_stop;
    fill_const(32'h0000_0ABC);
    run_meas(16'd0, 0, 1'b0);
    for (int c = 0; c <= m_hs; c++) begin
      tests++;
      if (obs_ctl[c] !== e_ctl[c] || obs_res[c] !== e_res[c] || obs_err[c] !== e_err[c]) begin
        fails++;
        $display("FAIL zero_gate cyc %0d: got ctl=%b res=%h err=%b, expected ctl=%b res=%h err=%b",
                 c, obs_ctl[c], obs_res[c], obs_err[c], e_ctl[c], e_res[c], e_err[c]);
      end
    end
    first_stop = -1; last_stop = -1;
    for (int c = 0; c <= m_hs; c++) if (obs_ctl[c][1]) begin
      if (first_stop < 0) first_stop = c;
      last_stop = c;
    end
    tests++;
    if (first_stop != 2 * H + 2 || last_stop != 3 * H + 1) begin
      fails++;
      $display("FAIL zero_gate_stop: got stop %0d..%0d, expected %0d..%0d",
               first_stop, last_stop, 2 * H + 2, 3 * H + 1);
    end
  endtask

  task automatic test_back_to_back;
    for (int r = 0; r < 2; r++) begin
      fill_const(32'h5000_0000 + 32'(r));
      run_meas(16'($urandom_range(1, 8)), r, 1'b0);
      for (int c = 0; c <= m_hs; c++) begin
        tests++;
        if (obs_ctl[c] !== e_ctl[c] || obs_res[c] !== e_res[c] || obs_err[c] !== e_err[c]) begin
          fails++;
          $display("FAIL b2b%0d cyc %0d: got ctl=%b res=%h err=%b, expected ctl=%b res=%h err=%b",
                   r, c, obs_ctl[c], obs_res[c], obs_err[c], e_ctl[c], e_res[c], e_err[c]);
        end
      end
    end
  endtask

  task automatic test_reset_in_gate;
    fill_const(32'h0000_7777);
    for (int c = 0; c <= 2 * H + 3; c++) begin
      @(negedge clk);
      go           = (c == 0);
      gate_len     = 16'd20;
      timer_count  = tc[c];
      result_ready = 1'b0;
      rst          = (c == 2 * H + 3);
    end
    @(negedge clk);
    go  = 1'b0;
    rst = 1'b0;
    tests++;
    if ({busy, timer_clear, timer_start, timer_stop, result_valid, result_err} !== 6'b0 ||
        result !== 32'h0) begin
      fails++;
      $display("FAIL reset_in_gate: got ctl=%b%b%b%b v=%b e=%b res=%h, expected all 0",
               busy, timer_clear, timer_start, timer_stop, result_valid, result_err, result);
    end
    prev_res = '0;
    prev_err = 1'b0;
    run_meas(16'd6, 1, 1'b0);
    for (int c = 0; c <= m_hs; c++) begin
      tests++;
      if (obs_ctl[c] !== e_ctl[c] || obs_res[c] !== e_res[c] || obs_err[c] !== e_err[c]) begin
        fails++;
        $display("FAIL after_reset cyc %0d: got ctl=%b res=%h err=%b, expected ctl=%b res=%h err=%b",
                 c, obs_ctl[c], obs_res[c], obs_err[c], e_ctl[c], e_res[c], e_err[c]);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] v;
    int          mode;
    for (int n = 0; n < 12; n++) begin
      mode = $urandom_range(0, 2);
      v    = $urandom;
      for (int c = 0; c < MAXC; c++) begin
        if (mode == 1 && $urandom_range(0, 3) == 0) v = $urandom;
        if (mode == 2) v = $urandom;
        tc[c] = v;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_meas(16'($urandom_range(0, 40)), $urandom_range(0, 6), 1'($urandom));
      for (int c = 0; c <= m_hs; c++) begin
        tests++;
        if (obs_ctl[c] !== e_ctl[c] || obs_res[c] !== e_res[c] || obs_err[c] !== e_err[c]) begin
          fails++;
          $display("FAIL random%0d cyc %0d: got ctl=%b res=%h err=%b, expected ctl=%b res=%h err=%b",
                   n, c, obs_ctl[c], obs_res[c], obs_err[c], e_ctl[c], e_res[c], e_err[c]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; gate_len = '0; timer_count = '0; result_ready = 1'b0;
    test_reset();
    test_basic();
    test_noisy();
    test_late_settle();
    test_backpressure();
    test_zero_gate();
    test_back_to_back();
    test_reset_in_gate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    fails++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
